// File: rtl/fifo_ctrl_non2n_if.sv
// Handshake and storage-array bus for the non-power-of-two FIFO controller.
// The producer/consumer side uses the master modport.
// The controller uses the slave modport.
interface fifo_ctrl_non2n_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 10
);
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;
  logic                  clr_err;
  logic                  mem_w_en;
  logic [PTR_WIDTH-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_r_en;
  logic [PTR_WIDTH-1:0]  mem_raddr;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PTR_WIDTH:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_req, wr_data, rd_req, clr_err,
    input  mem_w_en, mem_waddr, mem_wdata, mem_r_en, mem_raddr, rd_valid,
           full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_req, wr_data, rd_req, clr_err,
    output mem_w_en, mem_waddr, mem_wdata, mem_r_en, mem_raddr, rd_valid,
           full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_non2n.sv
// Pointer/occupancy controller for a FIFO storage array of arbitrary DEPTH.
// The array has a registered read port, so rd_valid marks the cycle after a read strobe.
// Pointers wrap at DEPTH-1 by explicit compare.
module fifo_ctrl_non2n #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 10,
  parameter int DEPTH      = 1000,
  parameter int AFULL_TH   = DEPTH - 4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_ctrl_non2n_if.slave  bus
);

  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0]   AF_LEVEL = (PTR_WIDTH+1)'(AFULL_TH);
  localparam logic [PTR_WIDTH:0]   AE_LEVEL = (PTR_WIDTH+1)'(AEMPTY_TH);

  logic [PTR_WIDTH-1:0]  wptr, wptr_nxt;
  logic [PTR_WIDTH-1:0]  rptr, rptr_nxt;
  logic [PTR_WIDTH:0]    cnt, cnt_nxt;
  logic                  valid_q;
  logic                  ovf_q, ovf_nxt;
  logic                  unf_q, unf_nxt;
  logic                  is_full, is_empty;
  logic                  wa, ra;
  logic [DATA_WIDTH-1:0] wdata;

  // Flags come only from the registered count, so acceptance never depends on the other request.
  always_comb begin
    is_full  = (cnt == CNT_FULL);
    is_empty = (cnt == '0);
    wa       = bus.wr_req & ~is_full;
    ra       = bus.rd_req & ~is_empty;
  end

  // Next pointers, occupancy and sticky errors; a set in the same cycle as a clear wins.
  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    cnt_nxt  = cnt;
    ovf_nxt  = ovf_q;
    unf_nxt  = unf_q;
    if (wa) wptr_nxt = (wptr == LAST_PTR) ? '0 : wptr + PTR_ONE;
    if (ra) rptr_nxt = (rptr == LAST_PTR) ? '0 : rptr + PTR_ONE;
    case ({wa, ra})
      2'b10:   cnt_nxt = cnt + CNT_ONE;
      2'b01:   cnt_nxt = cnt - CNT_ONE;
      default: cnt_nxt = cnt;
    endcase
    if (bus.clr_err) begin
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
    end
    if (bus.wr_req & is_full)  ovf_nxt = 1'b1;
    if (bus.rd_req & is_empty) unf_nxt = 1'b1;
  end

  // State register; reset drops any pending read-valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      cnt     <= cnt_nxt;
      valid_q <= ra;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  // Drive the array strobes, addresses and status outputs.
  always_comb begin
    wdata            = bus.wr_data;
    bus.mem_w_en     = wa;
    bus.mem_waddr    = wptr;
    bus.mem_wdata    = wdata;
    bus.mem_r_en     = ra;
    bus.mem_raddr    = rptr;
    bus.rd_valid     = valid_q;
    bus.full         = is_full;
    bus.empty        = is_empty;
    bus.almost_full  = (cnt >= AF_LEVEL);
    bus.almost_empty = (cnt <= AE_LEVEL);
    bus.count        = cnt;
    bus.overflow     = ovf_q;
    bus.underflow    = unf_q;
  end

endmodule

// File: tb/tb_fifo_ctrl_non2n.sv
// Bench for fifo_ctrl_non2n with DEPTH=5.
// A queue-based reference model predicts every output.
// A small registered-read array stands in for the storage so data order can be checked.
module tb_fifo_ctrl_non2n;
  localparam int DW = 8;
  localparam int PW = 3;
  localparam int DEPTH = 5;
  localparam int AF = 4;
  localparam int AE = 1;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  fifo_ctrl_non2n_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

  fifo_ctrl_non2n #(
    .DATA_WIDTH(DW), .PTR_WIDTH(PW), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  // Storage array with a registered read port, as the real array behaves
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] mem_rdata;
  always @(posedge clk) begin
    if (bus.mem_w_en) mem[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_r_en) mem_rdata <= mem[bus.mem_raddr];
  end

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int q[$];
  int wp, rp;
  bit ovf, unf, exp_valid;
  int exp_data;

  // Compare an observed value against the expected one, counting the comparison
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Return the model to its reset state
  task automatic modelReset();
    q.delete();
    wp = 0;
    rp = 0;
    ovf = 0;
    unf = 0;
    exp_valid = 0;
    exp_data = 0;
  endtask

  // Drive one cycle of requests, check all outputs against the model, then advance the model
  task automatic applyStimulus(input bit wr, input logic [DW-1:0] data, input bit rd, input bit clr);
    bit wa, ra;
    @(negedge clk);
    bus.wr_req  = wr;
    bus.wr_data = data;
    bus.rd_req  = rd;
    bus.clr_err = clr;
    #1;
    wa = wr && (q.size() < DEPTH);
    ra = rd && (q.size() > 0);
    checkOutput("mem_w_en", 32'(bus.mem_w_en), 32'(wa));
    checkOutput("mem_r_en", 32'(bus.mem_r_en), 32'(ra));
    checkOutput("mem_waddr", 32'(bus.mem_waddr), 32'(wp));
    checkOutput("mem_raddr", 32'(bus.mem_raddr), 32'(rp));
    checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(data));
    checkOutput("count", 32'(bus.count), 32'(q.size()));
    checkOutput("full", 32'(bus.full), 32'(q.size() == DEPTH));
    checkOutput("empty", 32'(bus.empty), 32'(q.size() == 0));
    checkOutput("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
    checkOutput("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
    checkOutput("overflow", 32'(bus.overflow), 32'(ovf));
    checkOutput("underflow", 32'(bus.underflow), 32'(unf));
    checkOutput("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
    if (exp_valid) checkOutput("rdata", 32'(mem_rdata), 32'(exp_data));
    @(posedge clk);
    if (wr && q.size() == DEPTH) ovf = 1;
    else if (clr) ovf = 0;
    if (rd && q.size() == 0) unf = 1;
    else if (clr) unf = 0;
    exp_valid = ra;
    if (ra) begin
      exp_data = q.pop_front();
      rp = (rp + 1) % DEPTH;
    end
    if (wa) begin
      q.push_back(int'(data));
      wp = (wp + 1) % DEPTH;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_data = '0;
    bus.rd_req = 1'b0;
    bus.clr_err = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state followed by filling with 0x11..0x55
    applyStimulus(0, 8'h00, 0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(1, 8'(i * 17), 0, 0);
    applyStimulus(1, 8'h66, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("fill_count", 32'(bus.count), 32'd5);
    checkOutput("fill_overflow", 32'(bus.overflow), 32'd1);

    // Drain back-to-back, then an extra read
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("drain_underflow", 32'(bus.underflow), 32'd1);
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);

    // Clear the sticky errors
    applyStimulus(0, 8'h00, 0, 1);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("clr_overflow", 32'(bus.overflow), 32'd0);

    // Wrap: write 3, read 3, write 4, read 4
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'(8'hB0 + i), 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(0, 8'h00, 0, 0);

    // Simultaneous requests at mid level, at full and at empty
    applyStimulus(1, 8'hC0, 0, 0);
    applyStimulus(1, 8'hC1, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 8'(8'hD0 + i), 1, 0);
    checkOutput("simul_count", 32'(bus.count), 32'd2);
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'hE0 + i), 0, 0);
    applyStimulus(1, 8'hEE, 1, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("simul_full_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(1, 8'hF0, 1, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("simul_empty_count", 32'(bus.count), 32'd1);

    // Reset mid-stream with count=3 and a read result pending
    applyStimulus(1, 8'h31, 0, 0);
    applyStimulus(1, 8'h32, 0, 0);
    applyStimulus(1, 8'h33, 1, 1);
    @(negedge clk);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.clr_err = 1'b0;
    #1;
    checkOutput("pre_rst_count", 32'(bus.count), 32'd3);
    checkOutput("pre_rst_valid", 32'(bus.rd_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    modelReset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Randomized traffic in phases biased toward filling or draining
    for (int p = 0; p < 6; p++) begin
      int wr_pct;
      wr_pct = (p % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 100; i++) begin
        applyStimulus(($urandom % 100) < wr_pct, 8'($urandom),
                      ($urandom % 100) < (100 - wr_pct), ($urandom % 20) == 0);
      end
    end
    applyStimulus(0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
